mbtrain_vref_sweep_ctrl: RTL and testbench

Sequencer for MBTRAIN VREF calibration. It sweeps the receiver VREF code across its full range and, for each code, runs one VREF-cal point-test handshake on the TX-side VREF calibration block. It records which codes pass on every lane and reports the centre of the widest contiguous passing window. It sits between the MBTRAIN LTSM state decode and the VREF calibration TX block, and drives that block's enable and VREF code.

---
 rtl/mbtrain_vref_sweep_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_mbtrain_vref_sweep_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mbtrain_vref_sweep_ctrl.sv
// mbtrain_vref_sweep_ctrl
//
// MBTRAIN VREF calibration sequencer. The block steps the receiver VREF code
// from 0 to 2^CODE_W-1. For each code it holds the code for SETTLE_CYC cycles
// and then runs one point-test handshake with the VREF-cal TX block. A code
// passes only when every lane passes. The block tracks the widest contiguous
// passing window and reports that window's centre code.
//
// Optional feature: define VREF_SWEEP_TIMEOUT_EN to add a per-code watchdog.
// The watchdog turns a missing ack into a failing code after TIMEOUT_CYC RUN
// cycles. Without the macro, RUN waits for the ack with no limit.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_en                         level enable; low returns the FSM to IDLE
//   i_start                      start a sweep (accepted only in IDLE)
//   i_mainband_or_valtrain_test  test select, latched at start
//   i_child_test_ack             child test complete (level)
//   i_rx_lanes_result            per-lane pass/fail, valid with the ack
//   o_child_en                   enable to the VREF cal TX block
//   o_mainband_or_valtrain_test  latched test select
//   o_vref_code                  VREF code currently applied
//   o_busy                       sweep in progress
//   o_done                       results valid (held until the next start)
//   o_pass                       best window length >= MIN_WINDOW
//   o_best_code                  centre code of the best window
module mbtrain_vref_sweep_ctrl #(
  parameter int CODE_W      = 4,
  parameter int NUM_LANES   = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int MIN_WINDOW  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_start,
  input  logic                 i_mainband_or_valtrain_test,
  input  logic                 i_child_test_ack,
  input  logic [NUM_LANES-1:0] i_rx_lanes_result,
  output logic                 o_child_en,
  output logic                 o_mainband_or_valtrain_test,
  output logic [CODE_W-1:0]    o_vref_code,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [CODE_W-1:0]    o_best_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Window lengths go up to 2^CODE_W, so they need one bit more than a code.
  localparam int LEN_W = CODE_W + 1;
  localparam int ST_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [ST_W-1:0]   SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
  localparam logic [CODE_W-1:0] CODE_LAST   = {CODE_W{1'b1}};
  localparam logic [LEN_W-1:0]  MIN_LEN     = LEN_W'(MIN_WINDOW);

  logic [2:0]        state;
  logic [ST_W-1:0]   settle_cnt;
  logic [CODE_W-1:0] code;
  logic              code_pass;
  logic [CODE_W-1:0] cur_start;
  logic [LEN_W-1:0]  cur_len;
  logic [CODE_W-1:0] best_start;
  logic [LEN_W-1:0]  best_len;
  logic              test_sel;
  logic              done_q;
  logic              pass_q;
  logic [CODE_W-1:0] best_code_q;

`ifdef VREF_SWEEP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wdog;
`endif

  // Window bookkeeping used by EVAL. open_start is the start of the window
  // that contains the current code (a new window starts here if none is open).
  logic [LEN_W-1:0]  cur_len_inc;
  logic [CODE_W-1:0] open_start;
  logic [LEN_W-1:0]  close_len;
  logic              closing;
  logic [LEN_W-1:0]  best_len_m1;
  logic [CODE_W-1:0] res_code;
  logic              res_pass;

  always_comb begin
    cur_len_inc = cur_len + 1'b1;
    open_start  = (cur_len == '0) ? code : cur_start;
    close_len   = code_pass ? cur_len_inc : cur_len;
    // A pass on the last code still closes the window so it can be ranked.
    closing     = !code_pass || (code == CODE_LAST);
    best_len_m1 = best_len - 1'b1;
    if (best_len == '0) begin
      res_code = '0;
      res_pass = 1'b0;
    end else begin
      res_code = best_start + best_len_m1[CODE_W:1];
      res_pass = (best_len >= MIN_LEN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      code        <= '0;
      code_pass   <= 1'b0;
      cur_start   <= '0;
      cur_len     <= '0;
      best_start  <= '0;
      best_len    <= '0;
      test_sel    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      best_code_q <= '0;
`ifdef VREF_SWEEP_TIMEOUT_EN
      wdog        <= '0;
`endif
    end else if (!i_en) begin
      // Abandon any sweep in progress; published results stay untouched.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            done_q     <= 1'b0;
            code       <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            test_sel   <= i_mainband_or_valtrain_test;
            settle_cnt <= '0;
            state      <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_RUN;
`ifdef VREF_SWEEP_TIMEOUT_EN
            wdog  <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (i_child_test_ack) begin
            code_pass <= &i_rx_lanes_result;
            state     <= S_EVAL;
          end
`ifdef VREF_SWEEP_TIMEOUT_EN
          else if (wdog == WD_LAST) begin
            code_pass <= 1'b0;
            state     <= S_EVAL;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        S_EVAL: begin
          if (closing) begin
            // Strictly longer replaces the best, so the first of equal windows wins.
            if (close_len > best_len) begin
              best_len   <= close_len;
              best_start <= open_start;
            end
            cur_len <= '0;
          end else begin
            cur_len   <= cur_len_inc;
            cur_start <= open_start;
          end
          state <= S_GAP;
        end
        S_GAP: begin
          // The terminal test sits here so the code counter never wraps.
          if (code == CODE_LAST) begin
            done_q      <= 1'b1;
            pass_q      <= res_pass;
            best_code_q <= res_code;
            state       <= S_DONE;
          end else begin
            code       <= code + 1'b1;
            settle_cnt <= '0;
            state      <= S_APPLY;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_child_en                  = (state == S_RUN);
  assign o_busy                      = (state == S_APPLY) || (state == S_RUN) ||
                                       (state == S_EVAL)  || (state == S_GAP);
  assign o_vref_code                 = code;
  assign o_mainband_or_valtrain_test = test_sel;
  assign o_done                      = done_q;
  assign o_pass                      = pass_q;
  assign o_best_code                 = best_code_q;

endmodule

// File: tb/tb_mbtrain_vref_sweep_ctrl.sv
module tb_mbtrain_vref_sweep_ctrl;

  localparam int CODE_W = 4;
  localparam int NCODES = 16;
  localparam int SETTLE = 4;
  localparam int TO_CYC = 20;
  localparam int WAIT_MAX = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_en = 1'b1;
  logic        i_start = 1'b0;
  logic        i_sel = 1'b0;
  logic        i_ack = 1'b0;
  logic [15:0] i_lanes = 16'h0;
  logic        o_child_en;
  logic        o_sel;
  logic [3:0]  o_vref_code;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic [3:0]  o_best_code;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] pat [NCODES];

  mbtrain_vref_sweep_ctrl #(
    .CODE_W(CODE_W), .NUM_LANES(16), .SETTLE_CYC(SETTLE),
    .MIN_WINDOW(2), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_start(i_start),
    .i_mainband_or_valtrain_test(i_sel),
    .i_child_test_ack(i_ack), .i_rx_lanes_result(i_lanes),
    .o_child_en(o_child_en), .o_mainband_or_valtrain_test(o_sel),
    .o_vref_code(o_vref_code), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_best_code(o_best_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scan the per-code pass list, keeping the first longest run.
  task automatic model(input int fail_code, output logic [3:0] bc, output logic bp);
    int best_l, best_s, run;
    best_l = 0; best_s = 0; run = 0;
    for (int s = 0; s < NCODES; s++) begin
      if ((pat[s] == 16'hFFFF) && (s != fail_code)) begin
        run++;
        if (run > best_l) begin
          best_l = run;
          best_s = s - run + 1;
        end
      end else begin
        run = 0;
      end
    end
    bc = (best_l == 0) ? 4'd0 : 4'(best_s + (best_l - 1) / 2);
    bp = (best_l >= 2);
  endtask

  function automatic logic [15:0] fail_word();
    logic [15:0] v;
    v = 16'($urandom);
    if (v == 16'hFFFF) v[$urandom_range(0, 15)] = 1'b0;
    return v;
  endfunction

  // One full sweep driven from the child side. abort_code drops i_en while
  // that code is in RUN; noack_code never acknowledges that code.
  task automatic do_sweep(input string name, input int abort_code, input int noack_code);
    logic       sel;
    logic [3:0] exp_bc;
    logic       exp_bp;
    int         cnt;
    int         lat;
    sel = 1'($urandom);
    @(negedge clk);
    i_start = 1'b1;
    i_sel   = sel;
    @(negedge clk);
    i_start = 1'b0;
    chk({name, "_busy_start"}, o_busy, 1);
    chk({name, "_done_clr"}, o_done, 0);
    chk({name, "_sel_latch"}, o_sel, sel);
    i_sel = ~sel;
    for (int c = 0; c < NCODES; c++) begin
      cnt = 0;
      while (!o_child_en && cnt < WAIT_MAX) begin
        @(negedge clk);
        i_start = 1'b0;
        cnt++;
      end
      if (cnt >= WAIT_MAX) begin
        chk({name, "_child_en_wait"}, 0, 1);
        return;
      end
      chk({name, "_en_low_cycles"}, cnt, (c == 0) ? SETTLE : SETTLE + 2);
      chk({name, "_vref_code"}, o_vref_code, c);
      if (c == abort_code) begin
        i_en = 1'b0;
        @(negedge clk);
        chk({name, "_abort_child_en"}, o_child_en, 0);
        chk({name, "_abort_busy"}, o_busy, 0);
        chk({name, "_abort_done"}, o_done, 0);
        i_en = 1'b1;
        repeat (3) @(negedge clk);
        chk({name, "_abort_idle"}, o_busy, 0);
        return;
      end
      if (c == noack_code) begin
        cnt = 0;
        while (o_child_en && cnt < TO_CYC + 10) begin
          @(negedge clk);
          cnt++;
        end
        chk({name, "_timeout_cycles"}, cnt, TO_CYC);
        continue;
      end
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        @(negedge clk);
        if (o_child_en !== 1'b1 || o_vref_code !== 4'(c))
          chk({name, "_run_stable"}, {o_child_en, o_vref_code}, {1'b1, 4'(c)});
      end
      i_ack   = 1'b1;
      i_lanes = pat[c];
      @(negedge clk);
      i_ack   = 1'b0;
      i_lanes = 16'($urandom);
      if (c == 2) i_start = 1'b1;
      if (o_child_en !== 1'b0 || o_busy !== 1'b1)
        chk({name, "_eval_ctrl"}, {o_child_en, o_busy}, 2'b01);
    end
    @(negedge clk);
    chk({name, "_gap_done"}, o_done, 0);
    @(negedge clk);
    model(noack_code, exp_bc, exp_bp);
    chk({name, "_done"}, o_done, 1);
    chk({name, "_busy_end"}, o_busy, 0);
    chk({name, "_best_code"}, o_best_code, exp_bc);
    chk({name, "_pass"}, o_pass, exp_bp);
    @(negedge clk);
    chk({name, "_done_hold"}, o_done, 1);
    chk({name, "_sel_hold"}, o_sel, sel);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_child_en", o_child_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_outs", {o_pass, o_best_code, o_vref_code, o_sel}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);

    for (int c = 0; c < NCODES; c++) pat[c] = 16'hFFFF;
    do_sweep("t1_all_pass", -1, -1);

    for (int c = 0; c < NCODES; c++)
      pat[c] = ((c >= 3 && c <= 8) || (c >= 11 && c <= 13)) ? 16'hFFFF : 16'h0000;
    do_sweep("t2_two_win", -1, -1);

    for (int c = 0; c < NCODES; c++)
      pat[c] = ((c >= 2 && c <= 4) || (c >= 9 && c <= 11)) ? 16'hFFFF : fail_word();
    do_sweep("t3_tie", -1, -1);

    for (int c = 0; c < NCODES; c++) pat[c] = 16'hFFFE;
    do_sweep("t4_all_fail", -1, -1);

    for (int c = 0; c < NCODES; c++) pat[c] = (c == 5) ? 16'h7FFF : 16'hFFFF;
    do_sweep("t5_hole", -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NCODES; c++)
        pat[c] = ($urandom_range(0, 2) != 0) ? 16'hFFFF : fail_word();
      do_sweep("rand", -1, -1);
    end

    do_sweep("t6_abort", 6, -1);
    for (int c = 0; c < NCODES; c++)
      pat[c] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : fail_word();
    do_sweep("after_abort", -1, -1);

`ifdef VREF_SWEEP_TIMEOUT_EN
    for (int c = 0; c < NCODES; c++) pat[c] = 16'hFFFF;
    do_sweep("t6_timeout", -1, 0);
`endif

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_child_en", o_child_en, 0);
    chk("arst_vref", o_vref_code, 0);
    chk("arst_outs", {o_done, o_pass, o_best_code, o_sel}, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
